alu_control_md: RTL and testbench

Parametrised successor to the single-cycle ALU control decoder. Adds full 7-bit funct7 decode, the branch, load/store and AUIPC ALU_Op classes, SRA/SLL/SLT/SLTU, and a multi-cycle sequencer for RV32M multiply/divide.
- Sits between the main control unit and the datapath.
- For single-cycle ops it drives the ALU operation combinationally.
- For M-extension ops it stalls the PC and pulses a start to the iterative multiply/divide unit for a parametrised number of cycles.

---
 rtl/alu_ctrl_pkg.sv | 38 +++
 rtl/alu_control_md_seq.sv | 50 +++++
 rtl/alu_control_md.sv | 62 ++++++
 tb/tb_alu_control_md.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/alu_ctrl_pkg.sv
// alu_ctrl_pkg: shared encodings and FSM state type for the ALU control decoder.
package alu_ctrl_pkg;
  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_LUI  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SLL  = 4'b0111;
  localparam logic [3:0] ALU_SRA  = 4'b1000;
  localparam logic [3:0] ALU_SLT  = 4'b1001;
  localparam logic [3:0] ALU_SLTU = 4'b1010;
  localparam logic [2:0] OP_R     = 3'b000;
  localparam logic [2:0] OP_I     = 3'b001;
  localparam logic [2:0] OP_LS    = 3'b010;
  localparam logic [2:0] OP_BR    = 3'b011;
  localparam logic [2:0] OP_LUI   = 3'b100;
  localparam logic [2:0] OP_AUIPC = 3'b101;
  localparam logic [6:0] F7_BASE  = 7'b0000000;
  localparam logic [6:0] F7_ALT   = 7'b0100000;
  localparam logic [6:0] F7_M     = 7'b0000001;
  localparam int CNT_W = 6;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} md_state_e;
  // alt selects SUB at funct3 000 and SRA at 101; callers gate where alt is legal
  function automatic logic [3:0] f3_to_alu(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction
endpackage

// File: rtl/alu_control_md_seq.sv
// md_sequencer: start/stall/result-select sequencing for the iterative mul/div unit.
module md_sequencer
  import alu_ctrl_pkg::*;
#(
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 33
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_mop,
  input  logic [2:0] i_funct3,
  output logic       o_start,
  output logic       o_stall,
  output logic       o_result_sel,
  output logic [2:0] o_md_op
);
  if (MUL_LAT < 1 || MUL_LAT > 64 || DIV_LAT < 1 || DIV_LAT > 64) begin : g_bad_lat
    $error("md_sequencer: MUL_LAT/DIV_LAT must be within 1..64");
  end
  md_state_e r_state, w_next;
  logic [CNT_W-1:0] r_cnt, w_lat_m1;
  logic [2:0] r_md_op;
  logic w_go;
  // a start is suppressed while reset is held so an aborted op cannot re-launch in the same cycle
  always_comb begin
    w_lat_m1     = i_funct3[2] ? CNT_W'(DIV_LAT - 1) : CNT_W'(MUL_LAT - 1);
    w_go         = (r_state == S_IDLE) & i_mop & ~reset;
    w_next       = r_state == S_IDLE ? (w_go ? (w_lat_m1 == '0 ? S_DONE : S_RUN) : S_IDLE) :
                   r_state == S_RUN  ? (r_cnt == CNT_W'(1) ? S_DONE : S_RUN) : S_IDLE;
    o_start      = w_go;
    o_stall      = w_go | (r_state == S_RUN);
    o_result_sel = r_state == S_DONE;
    o_md_op      = r_md_op;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_md_op <= '0;
    end else begin
      r_state <= w_next;
      if (w_go) begin
        r_cnt   <= w_lat_m1;
        r_md_op <= i_funct3;
      end else if (r_state == S_RUN) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
    end
  end
endmodule

// File: rtl/alu_control_md.sv
// alu_control_md: combinational ALU operation decoder with a multi-cycle RV32M sequencer.
module alu_control_md
  import alu_ctrl_pkg::*;
#(
  parameter int MUL_LAT  = 4,
  parameter int DIV_LAT  = 33,
  parameter bit ENABLE_M = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       valid_i,
  input  logic [6:0] funct7_i,
  input  logic [2:0] ALU_Op_i,
  input  logic [2:0] funct3_i,
  output logic [3:0] ALU_Operation_o,
  output logic       md_start_o,
  output logic [2:0] md_op_o,
  output logic       stall_o,
  output logic       result_sel_o,
  output logic       illegal_o
);
  logic w_base, w_alt, w_m_en, w_shift_r, w_i_ok, w_mop;
  always_comb begin
    w_base          = funct7_i == F7_BASE;
    w_alt           = funct7_i == F7_ALT;
    w_m_en          = (funct7_i == F7_M) & ENABLE_M;
    w_shift_r       = funct3_i == 3'b101;
    w_i_ok          = funct3_i == 3'b001 ? w_base : w_shift_r ? (w_base | w_alt) : 1'b1;
    w_mop           = valid_i & (ALU_Op_i == OP_R) & w_m_en;
    ALU_Operation_o = ALU_ADD;
    illegal_o       = 1'b0;
    case (ALU_Op_i)
      OP_R: begin
        // M encodings leave the ALU on ADD; the mul/div result is selected at write-back
        if (w_base) ALU_Operation_o = f3_to_alu(funct3_i, 1'b0);
        else if (w_alt && (funct3_i == 3'b000 || w_shift_r)) ALU_Operation_o = f3_to_alu(funct3_i, 1'b1);
        else if (!w_m_en) illegal_o = 1'b1;
      end
      OP_I: begin
        if (w_i_ok) ALU_Operation_o = f3_to_alu(funct3_i, w_shift_r & w_alt);
        else illegal_o = 1'b1;
      end
      OP_LS, OP_AUIPC: ALU_Operation_o = ALU_ADD;
      OP_BR:           ALU_Operation_o = ALU_SUB;
      OP_LUI:          ALU_Operation_o = ALU_LUI;
      default:         illegal_o = 1'b1;
    endcase
  end
  md_sequencer #(
    .MUL_LAT(MUL_LAT),
    .DIV_LAT(DIV_LAT)
  ) u_seq (
    .clk         (clk),
    .reset       (reset),
    .i_mop       (w_mop),
    .i_funct3    (funct3_i),
    .o_start     (md_start_o),
    .o_stall     (stall_o),
    .o_result_sel(result_sel_o),
    .o_md_op     (md_op_o)
  );
endmodule

// File: tb/tb_alu_control_md.sv
// tb_alu_control_md: table-driven decode checks plus cycle-scoreboarded mul/div sequences.
module tb_alu_control_md;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic valid = 1'b0;
  logic [6:0] funct7 = '0;
  logic [2:0] alu_op = '0;
  logic [2:0] funct3 = '0;
  logic [3:0] alu[3];
  logic [2:0] mdop[3];
  logic start[3], stall[3], rsel[3], ill[3];
  int passed = 0;
  int total = 0;

  always #5 clk = ~clk;

  // instance 0: default latencies; 1: single-cycle multiply; 2: M extension disabled
  alu_control_md #(.MUL_LAT(4), .DIV_LAT(33), .ENABLE_M(1'b1)) dut (
    .clk(clk), .reset(reset), .valid_i(valid), .funct7_i(funct7), .ALU_Op_i(alu_op),
    .funct3_i(funct3), .ALU_Operation_o(alu[0]), .md_start_o(start[0]), .md_op_o(mdop[0]),
    .stall_o(stall[0]), .result_sel_o(rsel[0]), .illegal_o(ill[0]));
  alu_control_md #(.MUL_LAT(1), .DIV_LAT(33), .ENABLE_M(1'b1)) dut_b (
    .clk(clk), .reset(reset), .valid_i(valid), .funct7_i(funct7), .ALU_Op_i(alu_op),
    .funct3_i(funct3), .ALU_Operation_o(alu[1]), .md_start_o(start[1]), .md_op_o(mdop[1]),
    .stall_o(stall[1]), .result_sel_o(rsel[1]), .illegal_o(ill[1]));
  alu_control_md #(.MUL_LAT(4), .DIV_LAT(33), .ENABLE_M(1'b0)) dut_n (
    .clk(clk), .reset(reset), .valid_i(valid), .funct7_i(funct7), .ALU_Op_i(alu_op),
    .funct3_i(funct3), .ALU_Operation_o(alu[2]), .md_start_o(start[2]), .md_op_o(mdop[2]),
    .stall_o(stall[2]), .result_sel_o(rsel[2]), .illegal_o(ill[2]));

  typedef struct {
    string nm;
    logic [2:0] op;
    logic [6:0] f7;
    logic [2:0] f3;
    logic [3:0] e_alu;
    logic e_ill;
  } vec_t;

  typedef struct {
    int sel;
    logic e_start, e_stall, e_rsel;
    logic [2:0] e_mdop;
    string nm;
  } seq_t;

  vec_t tbl[$];
  vec_t dq[$];
  seq_t sq[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // one clock of M-encoded stimulus; expected outputs of instance sel go through the scoreboard
  task automatic cyc(input int sel, input logic v, input logic rs, input logic [2:0] f3,
                     input logic es, input logic est, input logic er, input logic [2:0] emd,
                     input string nm);
    seq_t e;
    @(posedge clk);
    #1;
    reset = rs;
    valid = v;
    funct7 = 7'b0000001;
    alu_op = 3'b000;
    funct3 = f3;
    sq.push_back('{sel, es, est, er, emd, nm});
    @(negedge clk);
    e = sq.pop_front();
    chk({e.nm, ".start"}, 32'(start[e.sel]), 32'(e.e_start));
    chk({e.nm, ".stall"}, 32'(stall[e.sel]), 32'(e.e_stall));
    chk({e.nm, ".rsel"},  32'(rsel[e.sel]),  32'(e.e_rsel));
    chk({e.nm, ".mdop"},  32'(mdop[e.sel]),  32'(e.e_mdop));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t v;
    tbl.push_back('{"r_add",     3'b000, 7'b0000000, 3'b000, 4'b0000, 1'b0});
    tbl.push_back('{"r_sub",     3'b000, 7'b0100000, 3'b000, 4'b0001, 1'b0});
    tbl.push_back('{"r_sra",     3'b000, 7'b0100000, 3'b101, 4'b1000, 1'b0});
    tbl.push_back('{"r_sll",     3'b000, 7'b0000000, 3'b001, 4'b0111, 1'b0});
    tbl.push_back('{"r_sltu",    3'b000, 7'b0000000, 3'b011, 4'b1010, 1'b0});
    tbl.push_back('{"r_and",     3'b000, 7'b0000000, 3'b111, 4'b0010, 1'b0});
    tbl.push_back('{"i_sltiu",   3'b001, 7'b0101010, 3'b011, 4'b1010, 1'b0});
    tbl.push_back('{"i_addi_f7", 3'b001, 7'b0100000, 3'b000, 4'b0000, 1'b0});
    tbl.push_back('{"i_srai",    3'b001, 7'b0100000, 3'b101, 4'b1000, 1'b0});
    tbl.push_back('{"i_srli",    3'b001, 7'b0000000, 3'b101, 4'b0110, 1'b0});
    tbl.push_back('{"ldst",      3'b010, 7'b1111111, 3'b110, 4'b0000, 1'b0});
    tbl.push_back('{"branch",    3'b011, 7'b0000000, 3'b001, 4'b0001, 1'b0});
    tbl.push_back('{"lui",       3'b100, 7'b0000000, 3'b000, 4'b0101, 1'b0});
    tbl.push_back('{"auipc",     3'b101, 7'b0110011, 3'b111, 4'b0000, 1'b0});
    tbl.push_back('{"ill_r_alt", 3'b000, 7'b0100000, 3'b111, 4'b0000, 1'b1});
    tbl.push_back('{"ill_r_f7",  3'b000, 7'b0000010, 3'b000, 4'b0000, 1'b1});
    tbl.push_back('{"ill_op110", 3'b110, 7'b0000000, 3'b000, 4'b0000, 1'b1});
    tbl.push_back('{"ill_op111", 3'b111, 7'b0000000, 3'b100, 4'b0000, 1'b1});
    tbl.push_back('{"ill_slli",  3'b001, 7'b0100000, 3'b001, 4'b0000, 1'b1});

    // reset state of every instance
    for (int s = 0; s < 3; s++) cyc(s, 1'b0, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 3'b000, "reset");

    foreach (tbl[i]) begin
      @(posedge clk);
      #1;
      reset = 1'b0;
      valid = 1'b1;
      alu_op = tbl[i].op;
      funct7 = tbl[i].f7;
      funct3 = tbl[i].f3;
      dq.push_back(tbl[i]);
      @(negedge clk);
      v = dq.pop_front();
      chk({v.nm, ".alu"},   32'(alu[0]),   32'(v.e_alu));
      chk({v.nm, ".ill"},   32'(ill[0]),   32'(v.e_ill));
      chk({v.nm, ".stall"}, 32'(stall[0]), 32'(1'b0));
    end

    // MUL with MUL_LAT=4; M-op held through DONE must not restart
    cyc(0, 1'b1, 1'b0, 3'b000, 1'b1, 1'b1, 1'b0, 3'b000, "mul_c0");
    chk("m_off.ill",   32'(ill[2]),   32'(1'b1));
    chk("m_off.stall", 32'(stall[2]), 32'(1'b0));
    chk("m_off.start", 32'(start[2]), 32'(1'b0));
    chk("m_on.ill",    32'(ill[0]),   32'(1'b0));
    for (int c = 1; c < 4; c++) cyc(0, 1'b1, 1'b0, 3'b000, 1'b0, 1'b1, 1'b0, 3'b000, "mul_run");
    cyc(0, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1, 3'b000, "mul_done");
    cyc(0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 3'b000, "mul_idle");

    // DIV with DIV_LAT=33; funct3 changes mid-RUN and must not disturb md_op
    cyc(0, 1'b1, 1'b0, 3'b100, 1'b1, 1'b1, 1'b0, 3'b000, "div_c0");
    for (int c = 1; c < 33; c++)
      cyc(0, 1'b1, 1'b0, c < 10 ? 3'b100 : 3'b000, 1'b0, 1'b1, 1'b0, 3'b100, "div_run");
    cyc(0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1, 3'b100, "div_done");
    cyc(0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 3'b100, "div_idle");

    // reset during RUN aborts the op; held M-op restarts once reset drops
    cyc(0, 1'b1, 1'b0, 3'b001, 1'b1, 1'b1, 1'b0, 3'b100, "rst_c0");
    cyc(0, 1'b1, 1'b0, 3'b001, 1'b0, 1'b1, 1'b0, 3'b001, "rst_run1");
    cyc(0, 1'b1, 1'b1, 3'b001, 1'b0, 1'b1, 1'b0, 3'b001, "rst_run2");
    cyc(0, 1'b1, 1'b1, 3'b001, 1'b0, 1'b0, 1'b0, 3'b000, "rst_idle");
    cyc(0, 1'b1, 1'b0, 3'b001, 1'b1, 1'b1, 1'b0, 3'b000, "rst_restart");
    for (int c = 1; c < 4; c++) cyc(0, 1'b1, 1'b0, 3'b001, 1'b0, 1'b1, 1'b0, 3'b001, "rst_rerun");
    cyc(0, 1'b0, 1'b0, 3'b001, 1'b0, 1'b0, 1'b1, 3'b001, "rst_done");
    cyc(0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 3'b001, "rst_end");

    // MUL_LAT=1 back-to-back: start, DONE, start, DONE
    cyc(1, 1'b1, 1'b0, 3'b000, 1'b1, 1'b1, 1'b0, 3'b001, "b2b_s0");
    cyc(1, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1, 3'b000, "b2b_d0");
    cyc(1, 1'b1, 1'b0, 3'b000, 1'b1, 1'b1, 1'b0, 3'b000, "b2b_s1");
    cyc(1, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1, 3'b000, "b2b_d1");
    cyc(1, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 3'b000, "b2b_idle");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
